// File: rtl/coef_ram_arbiter_if.sv
// Bus bundle for the FIR coefficient RAM arbiter: SPI write side, FIR read side,
// RAM port and status. The arbiter uses the slave modport.
interface coef_ram_arbiter_if #(
    parameter int NUM_OF_FILTERS = 4,
    parameter int COEF_ADDR_BITS = 9,
    parameter int COEF_WIDTH     = 16,
    parameter int PEND_DEPTH     = 4
);
    localparam int FILT_BITS = $clog2(NUM_OF_FILTERS);
    localparam int ADDR_BITS = FILT_BITS + COEF_ADDR_BITS;
    localparam int CNT_BITS  = $clog2(PEND_DEPTH) + 1;

    logic                      coef_sel_stb;
    logic [7:0]                coef_select;
    logic [FILT_BITS-1:0]      filter_sel;
    logic [COEF_ADDR_BITS-1:0] num_coefs;
    logic                      coef_wr_stb;
    logic [COEF_WIDTH-1:0]     coef_wr_data;
    logic                      fir_rd_req;
    logic [ADDR_BITS-1:0]      fir_rd_addr;
    logic                      fir_rd_valid;
    logic [COEF_WIDTH-1:0]     fir_rd_data;
    logic                      ram_en;
    logic                      ram_we;
    logic [ADDR_BITS-1:0]      ram_addr;
    logic [COEF_WIDTH-1:0]     ram_wdata;
    logic [COEF_WIDTH-1:0]     ram_rdata;
    logic                      clear_ovf;
    logic [CNT_BITS-1:0]       pend_count;
    logic                      ovf_flag;
    logic                      busy;

    modport slave (
        input  coef_sel_stb, coef_select, filter_sel, num_coefs, coef_wr_stb,
               coef_wr_data, fir_rd_req, fir_rd_addr, ram_rdata, clear_ovf,
        output fir_rd_valid, fir_rd_data, ram_en, ram_we, ram_addr, ram_wdata,
               pend_count, ovf_flag, busy
    );

    modport master (
        output coef_sel_stb, coef_select, filter_sel, num_coefs, coef_wr_stb,
               coef_wr_data, fir_rd_req, fir_rd_addr, ram_rdata, clear_ovf,
        input  fir_rd_valid, fir_rd_data, ram_en, ram_we, ram_addr, ram_wdata,
               pend_count, ovf_flag, busy
    );
endinterface

// File: rtl/coef_ram_arbiter.sv
// Single-port coefficient RAM arbiter: FIR reads always win, SPI writes are queued
// in a small FIFO with an auto-incrementing index and drained in free cycles.
module coef_ram_arbiter #(
    parameter int NUM_OF_FILTERS = 4,
    parameter int COEF_ADDR_BITS = 9,
    parameter int COEF_WIDTH     = 16,
    parameter int PEND_DEPTH     = 4
) (
    input logic clk,
    input logic reset,
    coef_ram_arbiter_if.slave bus
);
    localparam int FILT_BITS = $clog2(NUM_OF_FILTERS);
    localparam int ADDR_BITS = FILT_BITS + COEF_ADDR_BITS;
    localparam int CNT_BITS  = $clog2(PEND_DEPTH) + 1;
    localparam int PTR_BITS  = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {IDLE, FIR_RD, SPI_WR} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_BITS+COEF_WIDTH-1:0] fifo_mem [PEND_DEPTH];
    logic [PTR_BITS-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]       count_q, count_d;
    logic [COEF_ADDR_BITS-1:0] wr_idx_q, wr_idx_d, last_idx;
    logic                      ovf_q, ovf_d;
    logic                      busy_q;
    logic [COEF_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      full, push, pop;
    logic [ADDR_BITS-1:0]      head_addr;
    logic [COEF_WIDTH-1:0]     head_data;
    logic                      ram_en_d, ram_we_d;
    logic [ADDR_BITS-1:0]      ram_addr_d;
    logic [COEF_WIDTH-1:0]     ram_wdata_d;

    assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

    // The decision is made combinationally so a FIR read hits the RAM in its own cycle;
    // reset forces IDLE so nothing reaches the RAM while it is held.
    always_comb begin
        state_d     = IDLE;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        if (!reset) begin
            if (bus.fir_rd_req)
                state_d = FIR_RD;
            else if (count_q != '0)
                state_d = SPI_WR;
        end
        case (state_d)
            FIR_RD: begin
                ram_en_d   = 1'b1;
                ram_addr_d = bus.fir_rd_addr;
            end
            SPI_WR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = head_addr;
                ram_wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        full     = (count_q == CNT_BITS'(PEND_DEPTH));
        push     = bus.coef_wr_stb && !full;
        pop      = (state_d == SPI_WR);
        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_BITS'(1);
        else if (pop && !push)
            count_d = count_q - CNT_BITS'(1);

        // num_coefs == 0 stands for a full 2^COEF_ADDR_BITS table
        last_idx = (bus.num_coefs == '0) ? '1 : bus.num_coefs - COEF_ADDR_BITS'(1);
        wr_idx_d = wr_idx_q;
        if (push)
            wr_idx_d = (wr_idx_q == last_idx) ? '0 : wr_idx_q + COEF_ADDR_BITS'(1);
        if (bus.coef_sel_stb)
            wr_idx_d = COEF_ADDR_BITS'(bus.coef_select);

        ovf_d = ovf_q;
        if (bus.clear_ovf)
            ovf_d = 1'b0;
        if (bus.coef_wr_stb && full)
            ovf_d = 1'b1;

        rd_data_d = (state_q == FIR_RD) ? bus.ram_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_idx_q  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_idx_q  <= wr_idx_d;
            ovf_q     <= ovf_d;
            busy_q    <= (count_d != '0);
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.filter_sel, wr_idx_q, bus.coef_wr_data};
    end

    assign bus.ram_en       = ram_en_d;
    assign bus.ram_we       = ram_we_d;
    assign bus.ram_addr     = ram_addr_d;
    assign bus.ram_wdata    = ram_wdata_d;
    assign bus.fir_rd_valid = (state_q == FIR_RD);
    assign bus.fir_rd_data  = rd_data_d;
    assign bus.pend_count   = count_q;
    assign bus.ovf_flag     = ovf_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Directed bench for coef_ram_arbiter: per-cycle vector table plus hand-written
// sequences for read-back and reset-with-pending-writes.
module tb_coef_ram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coef_ram_arbiter_if #(.NUM_OF_FILTERS(4), .COEF_ADDR_BITS(9), .COEF_WIDTH(16), .PEND_DEPTH(4)) bus ();

    coef_ram_arbiter #(.NUM_OF_FILTERS(4), .COEF_ADDR_BITS(9), .COEF_WIDTH(16), .PEND_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // RAM model: single port, registered read, read-first
    logic [15:0] mem [2048];
    logic [15:0] rdata_r = 16'h0;
    assign bus.ram_rdata = rdata_r;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            rdata_r <= mem[bus.ram_addr];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int we_seen = 0;
    bit mon_on = 1'b0;
    always @(negedge clk) if (mon_on && bus.ram_en && bus.ram_we) we_seen++;

    typedef struct {
        logic        sel;  logic [7:0]  sv;   logic [1:0] filt; logic wr;  logic [15:0] wd;
        logic        rd;   logic [10:0] ra;   logic clr;        logic [8:0] nc;
        logic        en;   logic we;          logic [10:0] ea;  logic [15:0] ewd;
        logic [2:0]  pend; logic ovf;         logic valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int sel, int sv, int filt, int wr, int wd, int rd, int ra, int clr,
                                int nc, int en, int we, int ea, int ewd, int pend, int ovf, int valid);
        vec_t v;
        v.sel = 1'(sel); v.sv = 8'(sv); v.filt = 2'(filt); v.wr = 1'(wr); v.wd = 16'(wd);
        v.rd = 1'(rd); v.ra = 11'(ra); v.clr = 1'(clr); v.nc = 9'(nc);
        v.en = 1'(en); v.we = 1'(we); v.ea = 11'(ea); v.ewd = 16'(ewd);
        v.pend = 3'(pend); v.ovf = 1'(ovf); v.valid = 1'(valid);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.coef_sel_stb = v.sel; bus.coef_select = v.sv; bus.filter_sel = v.filt;
        bus.coef_wr_stb  = v.wr;  bus.coef_wr_data = v.wd;
        bus.fir_rd_req   = v.rd;  bus.fir_rd_addr  = v.ra;
        bus.clear_ovf    = v.clr; bus.num_coefs    = v.nc;
    endtask

    task automatic idle_inputs();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ram_en"},    32'(bus.ram_en),      32'h0);
        chk({tag, ".ram_we"},    32'(bus.ram_we),      32'h0);
        chk({tag, ".ram_addr"},  32'(bus.ram_addr),    32'h0);
        chk({tag, ".ram_wdata"}, 32'(bus.ram_wdata),   32'h0);
        chk({tag, ".pend"},      32'(bus.pend_count),  32'h0);
        chk({tag, ".busy"},      32'(bus.busy),        32'h0);
        chk({tag, ".ovf"},       32'(bus.ovf_flag),    32'h0);
        chk({tag, ".valid"},     32'(bus.fir_rd_valid), 32'h0);
        chk({tag, ".rd_data"},   32'(bus.fir_rd_data), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        idle_inputs();

        // 1: start index 5, three writes, no FIR traffic (filter 2 -> 0x400 base)
        vecs.push_back(mk(1, 5, 2, 0, 0,       0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 1, 'h1111,  0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 1, 'h2222,  0, 0, 0, 0,  1, 1, 'h405, 'h1111,  1, 0, 0));
        vecs.push_back(mk(0, 0, 2, 1, 'h3333,  0, 0, 0, 0,  1, 1, 'h406, 'h2222,  1, 0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 0,       0, 0, 0, 0,  1, 1, 'h407, 'h3333,  1, 0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 0,       0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        // 2: num_coefs=3 wrap 1,2,0; then select+write together uses old index
        vecs.push_back(mk(1, 1, 0, 0, 0,       0, 0, 0, 3,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hA001,  0, 0, 0, 3,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hA002,  0, 0, 0, 3,  1, 1, 'h001, 'hA001,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hA003,  0, 0, 0, 3,  1, 1, 'h002, 'hA002,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0, 3,  1, 1, 'h000, 'hA003,  1, 0, 0));
        vecs.push_back(mk(1, 7, 0, 1, 'hA004,  0, 0, 0, 3,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hA005,  0, 0, 0, 3,  1, 1, 'h001, 'hA004,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0, 3,  1, 1, 'h007, 'hA005,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0, 3,  0, 0, 0,      0,       0, 0, 0));
        // 3: 10-cycle FIR burst with 2 writes queued (filter 3, index 16 -> 0x610)
        vecs.push_back(mk(1, 16, 3, 0, 0,      0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 1, 'hD001,  1, 1, 0, 0,  1, 0, 1,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 1, 'hD002,  1, 2, 0, 0,  1, 0, 2,      0,       1, 0, 1));
        for (int i = 3; i <= 10; i++)
            vecs.push_back(mk(0, 0, 3, 0, 0,   1, i, 0, 0,  1, 0, i,      0,       2, 0, 1));
        vecs.push_back(mk(0, 0, 3, 0, 0,       0, 0, 0, 0,  1, 1, 'h610, 'hD001,  2, 0, 1));
        vecs.push_back(mk(0, 0, 3, 0, 0,       0, 0, 0, 0,  1, 1, 'h611, 'hD002,  1, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0,       0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        // 4: overflow under FIR hold; clear together with overflow loses to set
        vecs.push_back(mk(1, 'h20, 1, 0, 0,    1, 0, 0, 0,  1, 0, 0,      0,       0, 0, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 0, 1, 1, 'hE000 + i, 1, 0, (i == 5), 0, 1, 0, 0, 0, i - 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,       1, 0, 0, 0,  1, 0, 0,      0,       4, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,       1, 0, 1, 0,  1, 0, 0,      0,       4, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,       1, 0, 0, 0,  1, 0, 0,      0,       4, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  1, 1, 'h220, 'hE001,  4, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  1, 1, 'h221, 'hE002,  3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  1, 1, 'h222, 'hE003,  2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  1, 1, 'h223, 'hE004,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 'hE006,  0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  1, 1, 'h224, 'hE006,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0, 0, 0,  0, 0, 0,      0,       0, 0, 0));

        // reset state, checked while reset is held
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1 apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d.ram_en", i),    32'(bus.ram_en),       32'(vecs[i].en));
            chk($sformatf("v%0d.ram_we", i),    32'(bus.ram_we),       32'(vecs[i].we));
            chk($sformatf("v%0d.ram_addr", i),  32'(bus.ram_addr),     32'(vecs[i].ea));
            chk($sformatf("v%0d.ram_wdata", i), 32'(bus.ram_wdata),    32'(vecs[i].ewd));
            chk($sformatf("v%0d.pend", i),      32'(bus.pend_count),   32'(vecs[i].pend));
            chk($sformatf("v%0d.busy", i),      32'(bus.busy),         32'(vecs[i].pend != 0));
            chk($sformatf("v%0d.ovf", i),       32'(bus.ovf_flag),     32'(vecs[i].ovf));
            chk($sformatf("v%0d.valid", i),     32'(bus.fir_rd_valid), 32'(vecs[i].valid));
            $display("vec %0d: en=%0d we=%0d addr=%0h wdata=%0h pend=%0d ovf=%0d valid=%0d",
                     i, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                     bus.pend_count, bus.ovf_flag, bus.fir_rd_valid);
        end

        // 5: write 0xBEEF to {1,9}, read it back after the drain
        @(posedge clk); #1 idle_inputs(); bus.coef_sel_stb = 1'b1; bus.coef_select = 8'd9;
        @(posedge clk); #1 idle_inputs(); bus.coef_wr_stb = 1'b1; bus.filter_sel = 2'd1;
        bus.coef_wr_data = 16'hBEEF;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("rb.wr_addr", 32'(bus.ram_addr), 32'h209);
        chk("rb.wr_we",   32'(bus.ram_we),   32'h1);
        @(posedge clk); #1 bus.fir_rd_req = 1'b1; bus.fir_rd_addr = 11'h209;
        @(negedge clk);
        chk("rb.rd_en", 32'(bus.ram_en), 32'h1);
        chk("rb.rd_we", 32'(bus.ram_we), 32'h0);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("rb.valid", 32'(bus.fir_rd_valid), 32'h1);
        chk("rb.data",  32'(bus.fir_rd_data),  32'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb.valid_off", 32'(bus.fir_rd_valid), 32'h0);
        chk("rb.data_hold", 32'(bus.fir_rd_data),  32'hBEEF);
        $display("readback: data=%0h", bus.fir_rd_data);

        // 6: reset with 3 writes pending; none may ever be issued
        @(posedge clk); #1 idle_inputs(); bus.coef_sel_stb = 1'b1; bus.coef_select = 8'h30;
        bus.fir_rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 bus.coef_sel_stb = 1'b0; bus.coef_wr_stb = 1'b1;
            bus.coef_wr_data = 16'(16'h7700 + i);
        end
        @(posedge clk); #1 bus.coef_wr_stb = 1'b0;
        @(negedge clk);
        chk("rst.pend_before", 32'(bus.pend_count), 32'h3);
        mon_on = 1'b1;
        @(posedge clk); #1 reset = 1'b1; idle_inputs();
        @(negedge clk);
        chk_quiet("rst.held");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_quiet("rst.after");
        mon_on = 1'b0;
        chk("rst.no_we", 32'(we_seen), 32'h0);
        $display("reset: pend=%0d writes_seen=%0d", bus.pend_count, we_seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
